id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised successor to the single-width instruction decode stage.
- Decodes opcode into control bits and reads a clocked, parametrised register file with optional zero register and write-through bypass.
- Sign-extends the immediate and registers everything into the ID/EX pipeline register.
- Adds valid tracking, downstream hold, branch flush and load-use hazard detection with bubble insertion. Sits between the IF/ID register and the execute stage.

Parameters:
XLEN, 32, datapath and register width; immediate is sign-extended from bit 15 to XLEN.
NREG, 32, number of architectural registers (power of two, 2..32).
RAW, 5, register address width; must equal log2(NREG); rs/rt/rd fields are instruction[25:21]/[20:16]/[15:11], truncated to RAW LSBs.
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and never causes a hazard.
INIT_INDEX, 1, 1 = reset loads register i with value i; 0 = reset clears all registers.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
instr_valid_s1  in  1  instruction_s1 holds a real instruction
instruction_s1  in  32  instruction from IF/ID
pc_out1_s1  in  32  PC+4 from IF/ID
write_data_s4  in  XLEN  writeback data
write_reg_s4  in  RAW  writeback register index
RegWrite_s4  in  1  writeback enable
flush  in  1  kill instruction_s1 (taken branch)
hold  in  1  downstream stall; freeze ID/EX register
stall_s1  out  1  combinational; IF and IF/ID must hold
valid_s2  out  1  ID/EX entry valid
ctrl_s2  out  9  {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp1,ALUOp0}
pc_out1_s2  out  32  registered PC+4
extended_32_s2  out  XLEN  registered sign-extended immediate
source_s2  out  RAW  registered rs
dest_for_I_s2  out  RAW  registered rt
dest_for_R_s2  out  RAW  registered rd
read_data1_s2  out  XLEN  registered rs data
read_data2_s2  out  XLEN  registered rt data

Behaviour:
- Reset (async, low): all s2 outputs, including valid_s2 and ctrl_s2, are 0. Register file is loaded per INIT_INDEX. stall_s1 is 0. Reset mid-operation discards the in-flight entry immediately.
- Control decode from instruction[31:26], as {RegDst..ALUOp0}:
  - 000000 (R): 1_0_0_1_0_0_0_1_0
  - 100011 (ALU-immediate): 0_1_0_1_0_0_0_0_0
  - 101011 (load): 0_1_1_1_1_0_0_0_0
  - 000100 (store): 0_1_0_0_0_1_0_0_0
  - 000101 (branch): 0_0_0_0_0_0_1_0_1
  - Any other opcode: 1_0_0_0_0_0_0_1_0 (no write).
- Register file:
  - Writes occur on the rising clk edge when RegWrite_s4=1. Writes to r0 are dropped when ZERO_REG=1.
  - Reads are combinational. With ZERO_REG=1, r0 reads 0.
- uses_rt: 1 for R, store and branch opcodes; 0 otherwise.
- hazard = valid_s2 & ctrl_s2[MemRead] & instr_valid_s1 & (dest_for_I_s2==rs | (uses_rt & dest_for_I_s2==rt)). Forced to 0 when dest_for_I_s2==0 and ZERO_REG=1.
- stall_s1 = (hazard | hold) & ~flush.
- ID/EX update each rising edge, priority high to low:
  1. flush: bubble.
  2. hold: all s2 registers keep their values.
  3. hazard: bubble.
  4. instr_valid_s1=0: bubble.
  5. Otherwise load: valid_s2=1 and all fields from the s1 decode.
- Bubble: valid_s2=0; ctrl_s2, data and index fields all 0.
- Latency: one cycle from s1 to s2. A load-use pair costs exactly one bubble; the stalled instruction re-evaluates the following cycle against the bubble, so hazard=0.
- A writeback and a hazard stall in the same cycle are independent: the write always commits.

Optional Feature:
- Macro: ID_FWD_BYPASS_EN.
- Defined: if RegWrite_s4=1 and write_reg_s4 equals the read index (excluding r0 when ZERO_REG=1), read data returns write_data_s4 in the same cycle (write-through).
- Not defined: read returns the pre-write value; the new value is visible from the next cycle.

Test Plan:
- Release reset with INIT_INDEX=1; issue R-type rs=3 rt=4 rd=5 -> next cycle valid_s2=1, ctrl_s2=9'b100100010, read_data1_s2=3, read_data2_s2=4, dest_for_R_s2=5.
- Load opcode 101011 with rt=7, then R-type with rs=7 -> stall_s1=1 for one cycle; one bubble (valid_s2=0, ctrl_s2=0); the R-type then enters s2 with valid_s2=1.
- Same cycle: write r9=0xDEADBEEF, decode rs=9 -> with ID_FWD_BYPASS_EN, read_data1_s2=0xDEADBEEF; without it, read_data1_s2=9.
- ZERO_REG=1: write r0=0x55, then read rs=0 -> read_data1_s2=0. Load with rt=0 followed by rs=0 -> no stall.
- Assert hold for 3 cycles -> s2 outputs constant and stall_s1=1. Assert flush together with hold -> valid_s2=0 next cycle and stall_s1=0.
- Assert reset low mid-stream with valid_s2=1 -> all s2 outputs go 0 without waiting for a clock edge; registers return to index values.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: opcode decode, clocked register file and ID/EX register with hold, flush and load-use bubbles.
// Define ID_FWD_BYPASS_EN to make register reads return same-cycle writeback data (write-through).
module id_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int RAW        = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit INIT_INDEX = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid_s1,
    input  logic [31:0]     instruction_s1,
    input  logic [31:0]     pc_out1_s1,
    input  logic [XLEN-1:0] write_data_s4,
    input  logic [RAW-1:0]  write_reg_s4,
    input  logic            RegWrite_s4,
    input  logic            flush,
    input  logic            hold,
    output logic            stall_s1,
    output logic            valid_s2,
    output logic [8:0]      ctrl_s2,
    output logic [31:0]     pc_out1_s2,
    output logic [XLEN-1:0] extended_32_s2,
    output logic [RAW-1:0]  source_s2,
    output logic [RAW-1:0]  dest_for_I_s2,
    output logic [RAW-1:0]  dest_for_R_s2,
    output logic [XLEN-1:0] read_data1_s2,
    output logic [XLEN-1:0] read_data2_s2
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ALUI = 6'b100011;
    localparam logic [5:0] OP_LD   = 6'b101011;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_BR   = 6'b000101;
    localparam int         MEMREAD = 4;

    typedef struct packed {
        logic            valid;
        logic [8:0]      ctrl;
        logic [31:0]     pc;
        logic [XLEN-1:0] imm;
        logic [RAW-1:0]  rs;
        logic [RAW-1:0]  rt;
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
    } idex_t;

    logic [5:0]      opcode;
    logic [RAW-1:0]  rs, rt, rd;
    logic [8:0]      ctrl;
    logic            uses_rt;
    logic [XLEN-1:0] rdata1, rdata2;
    logic            byp1, byp2;
    logic            hazard;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    idex_t           idex_q, idex_d, load_s1;

    assign opcode = instruction_s1[31:26];
    assign rs     = instruction_s1[21 +: RAW];
    assign rt     = instruction_s1[16 +: RAW];
    assign rd     = instruction_s1[11 +: RAW];

    always_comb begin
        ctrl    = (opcode == OP_R)    ? 9'b100100010 :
                  (opcode == OP_ALUI) ? 9'b010100000 :
                  (opcode == OP_LD)   ? 9'b011110000 :
                  (opcode == OP_ST)   ? 9'b010001000 :
                  (opcode == OP_BR)   ? 9'b000000101 : 9'b100000010;
        uses_rt = (opcode == OP_R) || (opcode == OP_ST) || (opcode == OP_BR);
    end

    always_comb begin
        regs_d = regs_q;
        if (RegWrite_s4 && !(ZERO_REG && write_reg_s4 == '0))
            regs_d[write_reg_s4] = write_data_s4;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= INIT_INDEX ? XLEN'(i) : '0;
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef ID_FWD_BYPASS_EN
    assign byp1 = RegWrite_s4 && (write_reg_s4 == rs);
    assign byp2 = RegWrite_s4 && (write_reg_s4 == rt);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // The r0 check comes first so a bypassed write to r0 still reads as zero.
    assign rdata1 = (ZERO_REG && rs == '0) ? '0 : byp1 ? write_data_s4 : regs_q[rs];
    assign rdata2 = (ZERO_REG && rt == '0) ? '0 : byp2 ? write_data_s4 : regs_q[rt];

    assign hazard = idex_q.valid && idex_q.ctrl[MEMREAD] && instr_valid_s1 &&
                    ((idex_q.rt == rs) || (uses_rt && idex_q.rt == rt)) &&
                    !(ZERO_REG && idex_q.rt == '0);
    assign stall_s1 = (hazard || hold) && !flush;

    always_comb begin
        load_s1       = '0;
        load_s1.valid = 1'b1;
        load_s1.ctrl  = ctrl;
        load_s1.pc    = pc_out1_s1;
        load_s1.imm   = {{(XLEN-16){instruction_s1[15]}}, instruction_s1[15:0]};
        load_s1.rs    = rs;
        load_s1.rt    = rt;
        load_s1.rd    = rd;
        load_s1.rd1   = rdata1;
        load_s1.rd2   = rdata2;
        idex_d        = flush                     ? '0 :
                        hold                      ? idex_q :
                        (hazard || !instr_valid_s1) ? '0 : load_s1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) idex_q <= '0;
        else        idex_q <= idex_d;
    end

    assign valid_s2       = idex_q.valid;
    assign ctrl_s2        = idex_q.ctrl;
    assign pc_out1_s2     = idex_q.pc;
    assign extended_32_s2 = idex_q.imm;
    assign source_s2      = idex_q.rs;
    assign dest_for_I_s2  = idex_q.rt;
    assign dest_for_R_s2  = idex_q.rd;
    assign read_data1_s2  = idex_q.rd1;
    assign read_data2_s2  = idex_q.rd2;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: scoreboard bench for id_stage_pipe (XLEN=32, NREG=32, ZERO_REG=1, INIT_INDEX=1).
module tb_id_stage_pipe;
    logic        clk = 1'b0, reset = 1'b1;
    logic        instr_valid_s1 = 1'b0;
    logic [31:0] instruction_s1 = '0, pc_out1_s1 = '0, write_data_s4 = '0;
    logic [4:0]  write_reg_s4 = '0;
    logic        RegWrite_s4 = 1'b0, flush = 1'b0, hold = 1'b0;
    logic        stall_s1, valid_s2;
    logic [8:0]  ctrl_s2;
    logic [31:0] pc_out1_s2, extended_32_s2, read_data1_s2, read_data2_s2;
    logic [4:0]  source_s2, dest_for_I_s2, dest_for_R_s2;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NREG(32), .RAW(5), .ZERO_REG(1'b1), .INIT_INDEX(1'b1)) dut (
        .clk(clk), .reset(reset), .instr_valid_s1(instr_valid_s1), .instruction_s1(instruction_s1),
        .pc_out1_s1(pc_out1_s1), .write_data_s4(write_data_s4), .write_reg_s4(write_reg_s4),
        .RegWrite_s4(RegWrite_s4), .flush(flush), .hold(hold), .stall_s1(stall_s1),
        .valid_s2(valid_s2), .ctrl_s2(ctrl_s2), .pc_out1_s2(pc_out1_s2),
        .extended_32_s2(extended_32_s2), .source_s2(source_s2), .dest_for_I_s2(dest_for_I_s2),
        .dest_for_R_s2(dest_for_R_s2), .read_data1_s2(read_data1_s2), .read_data2_s2(read_data2_s2)
    );

    typedef struct packed {
        logic v; logic [8:0] c; logic [31:0] pc; logic [31:0] ext;
        logic [4:0] s; logic [4:0] di; logic [4:0] dr; logic [31:0] r1; logic [31:0] r2;
    } ent_t;
    // k: 0 = bubble, 1 = load from s1 decode, 2 = keep previous entry
    typedef struct packed {
        logic v; logic [31:0] ins; logic fl; logic hd; logic st; logic [1:0] k;
        logic we; logic [4:0] wr; logic [31:0] wd;
    } row_t;

    ent_t        sb[$];
    ent_t        last_exp = '0, e, got;
    logic [31:0] mreg [32];
    logic [31:0] pcv = 32'h100;
    int          errors = 0, checks = 0;

    function automatic logic [8:0] dec(input logic [5:0] op);
        case (op)
            6'b000000: return 9'b100100010;
            6'b100011: return 9'b010100000;
            6'b101011: return 9'b011110000;
            6'b000100: return 9'b010001000;
            6'b000101: return 9'b000000101;
            default:   return 9'b100000010;
        endcase
    endfunction

    function automatic logic [31:0] rdm(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef ID_FWD_BYPASS_EN
        if (RegWrite_s4 && write_reg_s4 == a) return write_data_s4;
`endif
        return mreg[a];
    endfunction

    function automatic ent_t s2_now();
        return {valid_s2, ctrl_s2, pc_out1_s2, extended_32_s2, source_s2, dest_for_I_s2,
                dest_for_R_s2, read_data1_s2, read_data2_s2};
    endfunction

    function automatic logic [31:0] ins_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 11'h020};
    endfunction

    function automatic logic [31:0] ins_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic row_t mk(input logic v, input logic [31:0] ins, input logic fl, input logic hd,
                                input logic st, input logic [1:0] k, input logic we = 1'b0,
                                input logic [4:0] wr = 5'd0, input logic [31:0] wd = 32'd0);
        row_t r;
        r.v = v; r.ins = ins; r.fl = fl; r.hd = hd; r.st = st; r.k = k; r.we = we; r.wr = wr; r.wd = wd;
        return r;
    endfunction

    task automatic mreg_reset();
        for (int i = 0; i < 32; i++) mreg[i] = i;
    endtask

    task automatic drive(input row_t r);
        ent_t x;
        RegWrite_s4 = r.we; write_reg_s4 = r.wr; write_data_s4 = r.wd;
        instr_valid_s1 = r.v; instruction_s1 = r.ins; pc_out1_s1 = pcv; flush = r.fl; hold = r.hd;
        x = '0;
        if (r.k == 2'd1) begin
            x.v = 1'b1; x.c = dec(r.ins[31:26]); x.pc = pcv;
            x.ext = {{16{r.ins[15]}}, r.ins[15:0]};
            x.s = r.ins[25:21]; x.di = r.ins[20:16]; x.dr = r.ins[15:11];
            x.r1 = rdm(r.ins[25:21]); x.r2 = rdm(r.ins[20:16]);
        end else if (r.k == 2'd2) begin
            x = last_exp;
        end
        last_exp = x;
        sb.push_back(x);
        pcv += 4;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (RegWrite_s4 && write_reg_s4 != 5'd0) mreg[write_reg_s4] = write_data_s4;
        #1;
        RegWrite_s4 = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #2;
        checks++;
        if (s2_now() !== ent_t'(0)) begin errors++; $display("FAIL reset_s2 got=%h exp=0", s2_now()); end
        checks++;
        if (stall_s1 !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_s1); end
        @(posedge clk); #1;
        checks++;
        if (s2_now() !== ent_t'(0)) begin errors++; $display("FAIL reset_held got=%h exp=0", s2_now()); end
        reset = 1'b1;
        mreg_reset();
        last_exp = '0;
    endtask

    task automatic test_rtype();
        drive(mk(1'b1, ins_r(5'd3, 5'd4, 5'd5), 1'b0, 1'b0, 1'b0, 2'd1));
        checks++;
        if (stall_s1 !== 1'b0) begin errors++; $display("FAIL rtype_stall got=%b exp=0", stall_s1); end
        tick();
        e = sb.pop_front(); got = s2_now();
        checks++;
        if (got !== e) begin errors++; $display("FAIL rtype_s2 got=%h exp=%h", got, e); end
        checks++;
        if (valid_s2 !== 1'b1 || ctrl_s2 !== 9'b100100010)
            begin errors++; $display("FAIL rtype_ctrl got=%b/%b exp=1/100100010", valid_s2, ctrl_s2); end
        checks++;
        if (read_data1_s2 !== 32'd3 || read_data2_s2 !== 32'd4 || dest_for_R_s2 !== 5'd5)
            begin errors++; $display("FAIL rtype_data got=%0d/%0d/%0d exp=3/4/5", read_data1_s2, read_data2_s2, dest_for_R_s2); end
    endtask

    task automatic test_decode();
        row_t rows[$];
        rows.push_back(mk(1'b1, ins_i(6'b100011, 5'd2, 5'd6, 16'h8001), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_i(6'b101011, 5'd10, 5'd11, 16'h0010), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_i(6'b000100, 5'd1, 5'd2, 16'hfffc), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_i(6'b000101, 5'd4, 5'd5, 16'h0003), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_i(6'b111111, 5'd31, 5'd30, 16'h7fff), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b0, ins_r(5'd1, 5'd2, 5'd3), 1'b0, 1'b0, 1'b0, 2'd0));
        foreach (rows[i]) begin
            drive(rows[i]);
            checks++;
            if (stall_s1 !== rows[i].st) begin errors++; $display("FAIL decode_stall[%0d] got=%b exp=%b", i, stall_s1, rows[i].st); end
            tick();
            e = sb.pop_front(); got = s2_now();
            checks++;
            if (got !== e) begin errors++; $display("FAIL decode_s2[%0d] got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        rows.push_back(mk(1'b1, ins_i(6'b101011, 5'd1, 5'd7, 16'h0004), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_r(5'd7, 5'd2, 5'd3), 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 5'd12, 32'h1234));
        rows.push_back(mk(1'b1, ins_r(5'd7, 5'd2, 5'd3), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_i(6'b101011, 5'd1, 5'd8, 16'h0000), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_i(6'b000100, 5'd2, 5'd8, 16'h0000), 1'b0, 1'b0, 1'b1, 2'd0));
        rows.push_back(mk(1'b1, ins_i(6'b000100, 5'd2, 5'd8, 16'h0000), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_i(6'b101011, 5'd1, 5'd8, 16'h0000), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_i(6'b100011, 5'd2, 5'd8, 16'h0005), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_i(6'b101011, 5'd1, 5'd8, 16'h0000), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b0, ins_r(5'd8, 5'd8, 5'd1), 1'b0, 1'b0, 1'b0, 2'd0));
        rows.push_back(mk(1'b1, ins_r(5'd12, 5'd0, 5'd1), 1'b0, 1'b0, 1'b0, 2'd1));
        foreach (rows[i]) begin
            drive(rows[i]);
            checks++;
            if (stall_s1 !== rows[i].st) begin errors++; $display("FAIL loaduse_stall[%0d] got=%b exp=%b", i, stall_s1, rows[i].st); end
            tick();
            e = sb.pop_front(); got = s2_now();
            checks++;
            if (got !== e) begin errors++; $display("FAIL loaduse_s2[%0d] got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_bypass();
        drive(mk(1'b1, ins_r(5'd9, 5'd0, 5'd1), 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 5'd9, 32'hDEADBEEF));
        tick();
        e = sb.pop_front(); got = s2_now();
        checks++;
        if (got !== e) begin errors++; $display("FAIL bypass_s2 got=%h exp=%h", got, e); end
        checks++;
`ifdef ID_FWD_BYPASS_EN
        if (read_data1_s2 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd1 got=%h exp=deadbeef", read_data1_s2); end
`else
        if (read_data1_s2 !== 32'd9) begin errors++; $display("FAIL bypass_rd1 got=%h exp=00000009", read_data1_s2); end
`endif
        drive(mk(1'b1, ins_r(5'd9, 5'd9, 5'd1), 1'b0, 1'b0, 1'b0, 2'd1));
        tick();
        e = sb.pop_front(); got = s2_now();
        checks++;
        if (got !== e) begin errors++; $display("FAIL bypass_next_s2 got=%h exp=%h", got, e); end
        checks++;
        if (read_data2_s2 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_next_rd2 got=%h exp=deadbeef", read_data2_s2); end
    endtask

    task automatic test_zero_reg();
        row_t rows[$];
        rows.push_back(mk(1'b1, ins_r(5'd0, 5'd0, 5'd2), 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 5'd0, 32'h55));
        rows.push_back(mk(1'b1, ins_r(5'd0, 5'd0, 5'd2), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_i(6'b101011, 5'd1, 5'd0, 16'h0000), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_r(5'd0, 5'd0, 5'd2), 1'b0, 1'b0, 1'b0, 2'd1));
        foreach (rows[i]) begin
            drive(rows[i]);
            checks++;
            if (stall_s1 !== rows[i].st) begin errors++; $display("FAIL zero_stall[%0d] got=%b exp=%b", i, stall_s1, rows[i].st); end
            tick();
            e = sb.pop_front(); got = s2_now();
            checks++;
            if (got !== e) begin errors++; $display("FAIL zero_s2[%0d] got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_hold_flush();
        row_t rows[$];
        rows.push_back(mk(1'b1, ins_i(6'b100011, 5'd3, 5'd4, 16'h0009), 1'b0, 1'b0, 1'b0, 2'd1));
        for (int n = 0; n < 3; n++)
            rows.push_back(mk(1'b1, ins_r(5'd5, 5'd6, 5'd7), 1'b0, 1'b1, 1'b1, 2'd2));
        rows.push_back(mk(1'b1, ins_r(5'd5, 5'd6, 5'd7), 1'b1, 1'b1, 1'b0, 2'd0));
        rows.push_back(mk(1'b1, ins_r(5'd5, 5'd6, 5'd7), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_i(6'b101011, 5'd1, 5'd7, 16'h0000), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_r(5'd7, 5'd2, 5'd3), 1'b1, 1'b0, 1'b0, 2'd0));
        rows.push_back(mk(1'b1, ins_r(5'd7, 5'd2, 5'd3), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_i(6'b101011, 5'd1, 5'd7, 16'h0000), 1'b0, 1'b0, 1'b0, 2'd1));
        rows.push_back(mk(1'b1, ins_r(5'd7, 5'd2, 5'd3), 1'b0, 1'b1, 1'b1, 2'd2));
        rows.push_back(mk(1'b1, ins_r(5'd7, 5'd2, 5'd3), 1'b0, 1'b0, 1'b1, 2'd0));
        rows.push_back(mk(1'b1, ins_r(5'd7, 5'd2, 5'd3), 1'b0, 1'b0, 1'b0, 2'd1));
        foreach (rows[i]) begin
            drive(rows[i]);
            checks++;
            if (stall_s1 !== rows[i].st) begin errors++; $display("FAIL hold_stall[%0d] got=%b exp=%b", i, stall_s1, rows[i].st); end
            tick();
            e = sb.pop_front(); got = s2_now();
            checks++;
            if (got !== e) begin errors++; $display("FAIL hold_s2[%0d] got=%h exp=%h", i, got, e); end
        end
        hold = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(mk(1'b1, ins_r(5'd9, 5'd12, 5'd1), 1'b0, 1'b0, 1'b0, 2'd1));
        tick();
        e = sb.pop_front(); got = s2_now();
        checks++;
        if (got !== e || valid_s2 !== 1'b1) begin errors++; $display("FAIL midreset_pre got=%h exp=%h", got, e); end
        instr_valid_s1 = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (s2_now() !== ent_t'(0)) begin errors++; $display("FAIL midreset_s2 got=%h exp=0", s2_now()); end
        checks++;
        if (stall_s1 !== 1'b0) begin errors++; $display("FAIL midreset_stall got=%b exp=0", stall_s1); end
        #1 reset = 1'b1;
        mreg_reset();
        last_exp = '0;
        drive(mk(1'b1, ins_r(5'd9, 5'd12, 5'd1), 1'b0, 1'b0, 1'b0, 2'd1));
        tick();
        e = sb.pop_front(); got = s2_now();
        checks++;
        if (got !== e) begin errors++; $display("FAIL midreset_post got=%h exp=%h", got, e); end
        checks++;
        if (read_data1_s2 !== 32'd9 || read_data2_s2 !== 32'd12)
            begin errors++; $display("FAIL midreset_regs got=%h/%h exp=9/c", read_data1_s2, read_data2_s2); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_decode();
        test_load_use();
        test_bypass();
        test_zero_reg();
        test_hold_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
